// File: rtl/limit_sched_pkg.sv
// Shared types and helpers for the time-multiplexed limiter scheduler.
package limit_sched_pkg;

    typedef logic [31:0] float32_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Register stages inside the clamp core.
    localparam int unsigned CLAMP_LAT = 2;

    typedef struct packed {
        logic gt;
        logic lt;
    } fcmp_t;

    function automatic logic f32_is_nan(float32_t a);
        return (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    endfunction

    // Ordered compare of a against b in sign-magnitude form. Any NaN yields
    // neither gt nor lt; +0 and -0 compare equal.
    function automatic fcmp_t f32_cmp(float32_t a, float32_t b);
        fcmp_t      r;
        logic [30:0] ma;
        logic [30:0] mb;
        ma = a[30:0];
        mb = b[30:0];
        r  = '0;
        if (f32_is_nan(a) || f32_is_nan(b)) begin
            r = '0;
        end else if ((ma == 31'd0) && (mb == 31'd0)) begin
            r = '0;
        end else if (a[31] != b[31]) begin
            r.gt = !a[31];
            r.lt = a[31];
        end else if (!a[31]) begin
            r.gt = ma > mb;
            r.lt = ma < mb;
        end else begin
            r.gt = ma < mb;
            r.lt = ma > mb;
        end
        return r;
    endfunction

endpackage

// File: rtl/limit_clamp_core.sv
// Two-stage pipelined single-precision clamp: compare, then select.
module limit_clamp_core
    import limit_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  float32_t         x_i,
    input  float32_t         upper_i,
    input  float32_t         down_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output float32_t         y_o
);

    logic             v1_q;
    logic [TAG_W-1:0] tag1_q;
    float32_t         x1_q;
    float32_t         up1_q;
    float32_t         dn1_q;
    logic             gt_up_q;
    logic             lt_dn_q;
    logic             v2_q;
    logic [TAG_W-1:0] tag2_q;
    float32_t         y2_q;
    fcmp_t            c_up;
    fcmp_t            c_dn;

    assign c_up = f32_cmp(x_i, upper_i);
    assign c_dn = f32_cmp(x_i, down_i);

    // Valid bits are the only reset state in the pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
        end
    end

    // Stage 1: register operands and both compare results.
    always_ff @(posedge clk) begin
        tag1_q  <= tag_i;
        x1_q    <= x_i;
        up1_q   <= upper_i;
        dn1_q   <= down_i;
        gt_up_q <= c_up.gt;
        lt_dn_q <= c_dn.lt;
    end

    // Stage 2: priority select; holds last result while idle.
    always_ff @(posedge clk) begin
        if (v1_q) begin
            tag2_q <= tag1_q;
            if (gt_up_q) begin
                y2_q <= up1_q;
            end else if (lt_dn_q) begin
                y2_q <= dn1_q;
            end else begin
                y2_q <= x1_q;
            end
        end
    end

    assign valid_o = v2_q;
    assign tag_o   = tag2_q;
    assign y_o     = y2_q;

endmodule

// File: rtl/limit_sched_water.sv
// Limiter scheduler: per-channel samples/limits streamed through one clamp core.
module limit_sched_water
    import limit_sched_pkg::*;
#(
    parameter int unsigned CH        = 8,
    parameter int unsigned CH_W      = 3,
    parameter logic [31:0] DEF_UPPER = 32'h3f800000,
    parameter logic [31:0] DEF_DOWN  = 32'hbf800000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [31:0]     cfg_data,
    input  logic            in_we,
    input  logic [CH_W-1:0] in_ch,
    input  logic [31:0]     in_data,
    input  logic            sta,
    output logic            busy,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic [31:0]     out_data,
    output logic            done_sig,
    output logic            wr_drop
);

    float32_t        upper_q [CH];
    float32_t        down_q  [CH];
    float32_t        samp_q  [CH];
    state_e          state_q, state_d;
    logic [CH_W-1:0] cnt_q, cnt_d;
    logic            busy_q, done_q, wr_drop_q, wr_drop_d, seen_q;
    logic            iss_v_q;
    logic [CH_W-1:0] iss_ch_q;
    float32_t        iss_x_q, iss_up_q, iss_dn_q;
    logic            core_v;
    logic [CH_W-1:0] core_tag;
    float32_t        core_y;
    logic            sta_acc, drop;

    assign sta_acc = (state_q == StIdle) && sta;
    assign drop    = (cfg_we || in_we) && busy_q;

    // Storage arrays: reset to defaults, written only while not busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                upper_q[i] <= DEF_UPPER;
                down_q[i]  <= DEF_DOWN;
                samp_q[i]  <= '0;
            end
        end else begin
            if (cfg_we && !busy_q) begin
                if (cfg_sel) begin
                    down_q[cfg_ch] <= cfg_data;
                end else begin
                    upper_q[cfg_ch] <= cfg_data;
                end
            end
            if (in_we && !busy_q) begin
                samp_q[in_ch] <= in_data;
            end
        end
    end

    // FSM next state: the counter indexes channels in ISSUE and cycles in DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sta) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CH_W'(CH - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CH_W'(CLAMP_LAT - 1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sticky drop flag; a drop on the same edge as an accepted start wins.
    always_comb begin
        wr_drop_d = wr_drop_q;
        if (drop) begin
            wr_drop_d = 1'b1;
        end else if (sta_acc) begin
            wr_drop_d = 1'b0;
        end
    end

    // Control registers; busy and done lag the state by one cycle to line up
    // with the issue register and the core output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
            iss_v_q   <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_q != StIdle);
            done_q    <= (state_q == StDone);
            wr_drop_q <= wr_drop_d;
            iss_v_q   <= (state_q == StIssue);
            seen_q    <= seen_q || core_v;
        end
    end

    // Issue register: operands of the channel presented to the core.
    always_ff @(posedge clk) begin
        iss_ch_q <= cnt_q;
        iss_x_q  <= samp_q[cnt_q];
        iss_up_q <= upper_q[cnt_q];
        iss_dn_q <= down_q[cnt_q];
    end

    limit_clamp_core #(
        .TAG_W (CH_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .valid_i (iss_v_q),
        .tag_i   (iss_ch_q),
        .x_i     (iss_x_q),
        .upper_i (iss_up_q),
        .down_i  (iss_dn_q),
        .valid_o (core_v),
        .tag_o   (core_tag),
        .y_o     (core_y)
    );

    // Core data regs carry no reset; mask them to zero until a result appears.
    assign out_valid = core_v;
    assign out_ch    = (seen_q || core_v) ? core_tag : '0;
    assign out_data  = (seen_q || core_v) ? core_y : '0;
    assign busy      = busy_q;
    assign done_sig  = done_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_limit_sched_water.sv
// Directed bench for limit_sched_water.
module tb_limit_sched_water;

    localparam int CH   = 8;
    localparam int CH_W = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we, cfg_sel;
    logic [CH_W-1:0] cfg_ch;
    logic [31:0]     cfg_data;
    logic            in_we;
    logic [CH_W-1:0] in_ch;
    logic [31:0]     in_data;
    logic            sta;
    logic            busy, out_valid, done_sig, wr_drop;
    logic [CH_W-1:0] out_ch;
    logic [31:0]     out_data;

    int          vecs = 0;
    int          errs = 0;
    int          step_no = 0;
    logic [31:0] exp_res [CH];

    always #5 clk = ~clk;

    limit_sched_water #(
        .CH        (CH),
        .CH_W      (CH_W),
        .DEF_UPPER (32'h3f800000),
        .DEF_DOWN  (32'hbf800000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .in_we     (in_we),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .sta       (sta),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .done_sig  (done_sig),
        .wr_drop   (wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wr_cfg(input logic sel, input int ch, input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = CH_W'(ch); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wr_in(input int ch, input logic [31:0] d);
        in_we = 1'b1; in_ch = CH_W'(ch); in_data = d;
        @(posedge clk); #1;
        in_we = 1'b0;
    endtask

    // One step from an idle DUT; optionally attempts a sample write while busy.
    task automatic run_step(input bit inject);
        logic [31:0]  got [CH];
        int           vcyc [CH];
        int           nvalid, ndone, done_at;
        logic [CH+8:0] busy_at;
        logic         drop0;
        nvalid = 0; ndone = 0; done_at = -1;
        for (int k = 0; k < CH; k++) begin
            got[k]  = 'x;
            vcyc[k] = -1;
        end
        step_no++;
        sta = 1'b1;
        @(posedge clk); #1;
        sta = 1'b0;
        busy_at[0] = busy;
        drop0      = wr_drop;
        for (int c = 1; c <= CH + 8; c++) begin
            @(posedge clk); #1;
            if (inject && c == 3) in_we = 1'b0;
            busy_at[c] = busy;
            if (out_valid) begin
                nvalid++;
                if (vcyc[out_ch] < 0) begin
                    got[out_ch]  = out_data;
                    vcyc[out_ch] = c;
                end
            end
            if (done_sig) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (inject && c == 2) begin
                in_we = 1'b1; in_ch = 3'd2; in_data = 32'h40000000;
            end
        end
        chk($sformatf("s%0d wr_drop_after_sta", step_no), 32'(drop0), 32'd0);
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("s%0d ch%0d data", step_no, k), got[k], exp_res[k]);
            chk($sformatf("s%0d ch%0d cycle", step_no, k), 32'(vcyc[k]), 32'(3 + k));
        end
        chk($sformatf("s%0d done_cycle", step_no), 32'(done_at), 32'(CH + 3));
        chk($sformatf("s%0d done_count", step_no), 32'(ndone), 32'd1);
        chk($sformatf("s%0d valid_count", step_no), 32'(nvalid), 32'(CH));
        chk($sformatf("s%0d busy_t0", step_no), 32'(busy_at[0]), 32'd0);
        chk($sformatf("s%0d busy_t1", step_no), 32'(busy_at[1]), 32'd1);
        chk($sformatf("s%0d busy_last", step_no), 32'(busy_at[CH+3]), 32'd1);
        chk($sformatf("s%0d busy_end", step_no), 32'(busy_at[CH+4]), 32'd0);
        chk($sformatf("s%0d wr_drop_end", step_no), 32'(wr_drop), inject ? 32'd1 : 32'd0);
    endtask

    initial begin
        int nd, nv, bad_v, bad_d, bad_ch;
        rst = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_data = '0;
        in_we = 1'b0; in_ch = '0; in_data = '0; sta = 1'b0;
        for (int k = 0; k < CH; k++) exp_res[k] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_ch", 32'(out_ch), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst done_sig", 32'(done_sig), 32'd0);
        chk("rst wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Default limits over three samples.
        wr_in(0, 32'h40000000);
        wr_in(1, 32'hc0000000);
        wr_in(2, 32'h3f000000);
        exp_res[0] = 32'h3f800000; exp_res[1] = 32'hbf800000; exp_res[2] = 32'h3f000000;
        run_step(1'b0);

        // Channel 3 with limits [0, 3.0].
        wr_cfg(1'b0, 3, 32'h40400000);
        wr_cfg(1'b1, 3, 32'h00000000);
        wr_in(3, 32'h40800000);
        exp_res[3] = 32'h40400000;
        run_step(1'b0);
        wr_in(3, 32'hbf800000);
        exp_res[3] = 32'h00000000;
        run_step(1'b0);
        wr_in(3, 32'h80000000);
        exp_res[3] = 32'h80000000;
        run_step(1'b0);

        // NaN pass-through and misconfigured limits.
        wr_in(5, 32'h7fc00000);
        wr_cfg(1'b0, 6, 32'h00000000);
        wr_cfg(1'b1, 6, 32'h3f800000);
        wr_in(6, 32'h3f000000);
        exp_res[5] = 32'h7fc00000; exp_res[6] = 32'h00000000;
        run_step(1'b0);

        // sta held high for 30 edges: steps at offsets 0, 12, 24.
        nd = 0; nv = 0; bad_v = 0; bad_d = 0; bad_ch = 0;
        sta = 1'b1;
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            if (c == 29) sta = 1'b0;
            if (out_valid) nv++;
            if (done_sig) nd++;
            if (out_valid !== (c < 36 && (c % 12) >= 3 && (c % 12) <= 10)) bad_v++;
            if (done_sig !== (c < 36 && (c % 12) == 11)) bad_d++;
            if (out_valid && (int'(out_ch) != (c % 12) - 3)) bad_ch++;
        end
        chk("cont done_count", 32'(nd), 32'd3);
        chk("cont valid_count", 32'(nv), 32'd24);
        chk("cont valid_pattern_errs", 32'(bad_v), 32'd0);
        chk("cont done_pattern_errs", 32'(bad_d), 32'd0);
        chk("cont out_ch_seq_errs", 32'(bad_ch), 32'd0);

        // Write during busy is dropped; next step clears the flag.
        run_step(1'b1);
        run_step(1'b0);

        // Reset in the middle of ISSUE.
        sta = 1'b1;
        @(posedge clk); #1;
        sta = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst done_sig", 32'(done_sig), 32'd0);
        chk("midrst out_data", out_data, 32'd0);
        chk("midrst out_ch", 32'(out_ch), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < CH; k++) exp_res[k] = 32'h0;
        run_step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
